// File: rtl/cdce_cfg_pkg.sv
// Shared constants for the CDCE configuration sequencer: command field widths,
// opcodes and the sequencer state encoding.
package cdce_cfg_pkg;

   localparam int unsigned CmdW     = 36;
   localparam int unsigned PayloadW = 32;
   localparam int unsigned OpW      = 4;
   localparam int unsigned AddrW    = 8;

   localparam logic [OpW-1:0] OpEnd   = 4'h0;
   localparam logic [OpW-1:0] OpWrite = 4'h1;
   localparam logic [OpW-1:0] OpWait  = 4'h2;
   localparam logic [OpW-1:0] OpRead  = 4'h3;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StRomWait,
      StDecode,
      StShift,
      StLatch,
      StDelay,
      StFault
   } state_e;

endpackage

// File: rtl/cdce_spi_shifter.sv
// 32-bit MSB-first SPI serializer with sclk divider. Optional MISO capture
// (rd_data_o / rd_valid_o) is built when CDCE_READBACK_EN is defined.
module cdce_spi_shifter
   import cdce_cfg_pkg::*;
#(
   parameter int unsigned SclkHalf = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic [PayloadW-1:0] data_i,
`ifdef CDCE_READBACK_EN
   input  logic                capture_i,
   input  logic                miso_i,
   output logic [PayloadW-1:0] rd_data_o,
   output logic                rd_valid_o,
`endif
   output logic                sclk_o,
   output logic                mosi_o,
   output logic                last_o
);

   logic                active_q, active_d;
   logic                phase_q, phase_d;
   logic [7:0]          half_q, half_d;
   logic [4:0]          bit_q, bit_d;
   logic [PayloadW-1:0] sr_q, sr_d;
   logic                half_end;
`ifdef CDCE_READBACK_EN
   logic                cap_q, cap_d;
   logic [PayloadW-1:0] rx_q, rx_d;
   logic [PayloadW-1:0] rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
`endif

   assign half_end = (half_q == 8'(SclkHalf - 1));
   // phase_q low = first half of a bit (mosi settles), high = sclk high
   assign sclk_o   = active_q & phase_q;
   assign mosi_o   = active_q & sr_q[PayloadW-1];
   assign last_o   = active_q & phase_q & half_end & (bit_q == 5'd31);
`ifdef CDCE_READBACK_EN
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
`endif

   // Divider and shift register next state; miso is taken on the sclk rising edge.
   always_comb begin
      active_d = active_q;
      phase_d  = phase_q;
      half_d   = half_q;
      bit_d    = bit_q;
      sr_d     = sr_q;
`ifdef CDCE_READBACK_EN
      cap_d      = cap_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
`endif
      if (load_i) begin
         active_d = 1'b1;
         phase_d  = 1'b0;
         half_d   = '0;
         bit_d    = '0;
         sr_d     = data_i;
`ifdef CDCE_READBACK_EN
         cap_d    = capture_i;
`endif
      end else if (active_q) begin
         if (half_end) begin
            half_d = '0;
            if (!phase_q) begin
               phase_d = 1'b1;
`ifdef CDCE_READBACK_EN
               rx_d = {rx_q[PayloadW-2:0], miso_i};
`endif
            end else begin
               phase_d = 1'b0;
               if (bit_q == 5'd31) begin
                  active_d = 1'b0;
`ifdef CDCE_READBACK_EN
                  if (cap_q) begin
                     rd_data_d  = rx_q;
                     rd_valid_d = 1'b1;
                  end
`endif
               end else begin
                  bit_d = bit_q + 5'd1;
                  sr_d  = {sr_q[PayloadW-2:0], 1'b0};
               end
            end
         end else begin
            half_d = half_q + 8'd1;
         end
      end
   end

   // Shifter state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         phase_q  <= 1'b0;
         half_q   <= '0;
         bit_q    <= '0;
         sr_q     <= '0;
`ifdef CDCE_READBACK_EN
         cap_q      <= 1'b0;
         rx_q       <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
`endif
      end else begin
         active_q <= active_d;
         phase_q  <= phase_d;
         half_q   <= half_d;
         bit_q    <= bit_d;
         sr_q     <= sr_d;
`ifdef CDCE_READBACK_EN
         cap_q      <= cap_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
`endif
      end
   end

endmodule

// File: rtl/cdce_config_sequencer.sv
// Walks a 256-entry command ROM (two-cycle fetch) and issues CDCE SPI frames,
// waits and an end marker. Macro CDCE_READBACK_EN adds the READ opcode and the
// spi_miso / rd_data / rd_valid ports.
module cdce_config_sequencer
   import cdce_cfg_pkg::*;
#(
   parameter int unsigned SCLK_HALF = 4,
   parameter int unsigned LE_HIGH   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic [AddrW-1:0]    rom_address,
   input  logic [CmdW-1:0]     rom_command,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic                spi_sclk,
   output logic                spi_le,
   output logic                spi_mosi
`ifdef CDCE_READBACK_EN
   ,
   input  logic                spi_miso,
   output logic [PayloadW-1:0] rd_data,
   output logic                rd_valid
`endif
);

   state_e              state_q, state_d;
   logic [AddrW-1:0]    addr_q, addr_d;
   logic [23:0]         cnt_q, cnt_d;
   logic [OpW-1:0]      opcode;
   logic [PayloadW-1:0] payload;
   logic                advance;
   logic                shift_load, shift_last, shift_sclk, shift_mosi;
   logic [PayloadW-1:0] shift_data;
`ifdef CDCE_READBACK_EN
   logic                rd_pend_q, rd_pend_d;
   logic                shift_capture;
`endif

   assign opcode      = rom_command[CmdW-1:PayloadW];
   assign payload     = rom_command[PayloadW-1:0];
   assign rom_address = addr_q;

   cdce_spi_shifter #(
      .SclkHalf (SCLK_HALF)
   ) u_shifter (
      .clk_i      (clk),
      .rst_i      (reset),
      .load_i     (shift_load),
      .data_i     (shift_data),
`ifdef CDCE_READBACK_EN
      .capture_i  (shift_capture),
      .miso_i     (spi_miso),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid),
`endif
      .sclk_o     (shift_sclk),
      .mosi_o     (shift_mosi),
      .last_o     (shift_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         cnt_q     <= '0;
`ifdef CDCE_READBACK_EN
         rd_pend_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
`ifdef CDCE_READBACK_EN
         rd_pend_q <= rd_pend_d;
`endif
      end
   end

   // Next-state logic; 'advance' moves to the next command or faults past 255.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      advance    = 1'b0;
      shift_load = 1'b0;
      shift_data = payload;
`ifdef CDCE_READBACK_EN
      rd_pend_d     = rd_pend_q;
      shift_capture = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d  = '0;
               state_d = StFetch;
            end
         end
         StFetch:   state_d = StRomWait;
         StRomWait: state_d = StDecode;
         StDecode: begin
            case (opcode)
               OpEnd:   state_d = StIdle;
               OpWrite: begin
                  shift_load = 1'b1;
                  state_d    = StShift;
               end
               OpWait: begin
                  if (payload[23:0] == 24'd0) begin
                     advance = 1'b1;
                  end else begin
                     cnt_d   = payload[23:0];
                     state_d = StDelay;
                  end
               end
`ifdef CDCE_READBACK_EN
               OpRead: begin
                  shift_load = 1'b1;
                  rd_pend_d  = 1'b1;
                  state_d    = StShift;
               end
`endif
               default: state_d = StFault;
            endcase
         end
         StShift: begin
            if (shift_last) begin
               cnt_d   = 24'(LE_HIGH);
               state_d = StLatch;
            end
         end
         StLatch: begin
            if (cnt_q <= 24'd1) begin
`ifdef CDCE_READBACK_EN
               if (rd_pend_q) begin
                  // Second frame of a READ: clock out zeros while capturing miso.
                  rd_pend_d     = 1'b0;
                  shift_load    = 1'b1;
                  shift_data    = '0;
                  shift_capture = 1'b1;
                  state_d       = StShift;
               end else begin
                  advance = 1'b1;
               end
`else
               advance = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         StDelay: begin
            if (cnt_q <= 24'd1) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         StFault: state_d = StFault;
         default: state_d = StIdle;
      endcase
      if (advance) begin
         if (addr_q == '1) begin
            state_d = StFault;
         end else begin
            addr_d  = addr_q + 8'd1;
            state_d = StFetch;
         end
      end
   end

   // Outputs decoded from the current state; SPI pins are quiet outside SHIFT.
   always_comb begin
      done     = (state_q == StDecode) && (opcode == OpEnd);
      busy     = (state_q != StIdle) && (state_q != StFault) && !done;
      error    = (state_q == StFault);
      spi_le   = (state_q != StShift);
      spi_sclk = (state_q == StShift) && shift_sclk;
      spi_mosi = (state_q == StShift) && shift_mosi;
   end

endmodule

// File: tb/tb_cdce_config_sequencer.sv
// Bench for cdce_config_sequencer. Expected per-cycle outputs are expanded from
// the ROM program by timing rules; CDCE_READBACK_EN selects the readback tests.
module tb_cdce_config_sequencer;

   localparam int H = 4;
   localparam int L = 8;
`ifdef CDCE_READBACK_EN
   localparam bit ReadOk = 1'b1;
`else
   localparam bit ReadOk = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rom_address;
   logic [35:0] rom_command;
   logic        busy, done, error, spi_sclk, spi_le, spi_mosi;
   logic        spi_miso = 1'b0;
   logic [31:0] rd_data;
   logic        rd_valid;

   cdce_config_sequencer #(
      .SCLK_HALF (H),
      .LE_HIGH   (L)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .rom_address (rom_address),
      .rom_command (rom_command),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .spi_sclk    (spi_sclk),
      .spi_le      (spi_le),
      .spi_mosi    (spi_mosi)
`ifdef CDCE_READBACK_EN
      ,
      .spi_miso    (spi_miso),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid)
`endif
   );

`ifndef CDCE_READBACK_EN
   assign rd_data  = '0;
   assign rd_valid = 1'b0;
`endif

   always #5 clk = ~clk;

   // Command ROM with two-cycle read latency.
   logic [35:0] rom [256];
   logic [35:0] rom_p1;
   always @(posedge clk) begin
      rom_p1      <= rom[rom_address];
      rom_command <= rom_p1;
   end

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       err;
      logic       sclk;
      logic       le;
      logic       mosi;
      logic       rdv;
      logic       miso;
      logic [7:0] addr;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          g_done_idx, g_rises, g_rdv_cnt;
   logic [31:0] g_bits;
   logic [31:0] g_rd_word = 32'h0;

   function automatic exp_t mk(input logic b, dn, er, sc, le, mo, rv, mi, input logic [7:0] a);
      exp_t e;
      e.busy = b; e.done = dn; e.err = er; e.sclk = sc; e.le = le;
      e.mosi = mo; e.rdv = rv; e.miso = mi; e.addr = a;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // One frame: 32 bits, each H cycles low then H cycles high, MSB first.
   task automatic add_frame(input logic [31:0] d, input logic [31:0] rx, input logic [7:0] a);
      for (int i = 0; i < 64 * H; i++) begin
         int b;
         b = 31 - i / (2 * H);
         exp_q.push_back(mk(1, 0, 0, ((i / H) % 2) == 1, 0, d[b], 0, rx[b], a));
      end
   endtask

   task automatic add_latch(input logic [7:0] a, input logic first_rdv);
      for (int i = 0; i < L; i++) exp_q.push_back(mk(1, 0, 0, 0, 1, 0, first_rdv && i == 0, 0, a));
   endtask

   task automatic add_fault(input logic [7:0] a);
      repeat (8) exp_q.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, a));
   endtask

   // Expand the ROM program into the cycle-by-cycle output trace after start.
   task automatic build_trace();
      logic [3:0]  op;
      logic [31:0] pl;
      logic [7:0]  a;
      bit          fin;
      exp_q.delete();
      fin = 0;
      for (int pc = 0; pc < 256 && !fin; pc++) begin
         op = rom[pc][35:32];
         pl = rom[pc][31:0];
         a  = 8'(pc);
         repeat (2) exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, a));
         exp_q.push_back(mk(op != 0, op == 0, 0, 0, 1, 0, 0, 0, a));
         if (op == 0) begin
            repeat (4) exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, a));
            fin = 1;
         end else if (op == 1 || (ReadOk && op == 3)) begin
            add_frame(pl, 32'h0, a);
            add_latch(a, 0);
            if (op == 3) begin
               add_frame(32'h0, g_rd_word, a);
               add_latch(a, 1);
            end
         end else if (op == 2) begin
            for (int k = 0; k < int'(pl[23:0]); k++) exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, a));
         end else begin
            add_fault(a);
            fin = 1;
         end
      end
      if (!fin) add_fault(8'd255);
   endtask

   function automatic int model_done_idx();
      foreach (exp_q[i]) if (exp_q[i].done) return i;
      return -1;
   endfunction

   // Pulse start, then compare every cycle of the trace (or the first 'limit').
   task automatic run_trace(input int limit);
      int   n;
      exp_t d;
      logic prev;
      n = (limit < 0) ? exp_q.size() : limit;
      g_done_idx = -1; g_rises = 0; g_bits = '0; g_rdv_cnt = 0; prev = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0;
         d = mk(busy, done, error, spi_sclk, spi_le, spi_mosi, rd_valid, exp_q[i].miso, rom_address);
         checks++;
         if (d !== exp_q[i]) begin
            errors++;
            $display("FAIL trace cycle %0d: got %h, expected %h", i, d, exp_q[i]);
            break;
         end
`ifdef CDCE_READBACK_EN
         if (exp_q[i].rdv) check("rd_data", rd_data, g_rd_word);
`endif
         if (spi_sclk && !prev) begin
            g_rises++;
            g_bits = {g_bits[30:0], spi_mosi};
         end
         prev = spi_sclk;
         if (done && g_done_idx < 0) g_done_idx = i;
         if (rd_valid) g_rdv_cnt++;
         spi_miso = exp_q[i].miso;
      end
      spi_miso = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst rom_address", 32'(rom_address), 0);
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst error", 32'(error), 0);
      check("rst spi_sclk", 32'(spi_sclk), 0);
      check("rst spi_le", 32'(spi_le), 1);
      check("rst spi_mosi", 32'(spi_mosi), 0);
      check("rst rd_data", rd_data, 0);
      check("rst rd_valid", 32'(rd_valid), 0);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pl;
      int          n;
      foreach (rom[i]) rom[i] = 36'h0;
      do_reset();

      // Single WRITE frame then END.
      rom[0] = 36'h1_12345678;
      rom[1] = 36'h0_00000000;
      build_trace();
      check("model write done idx", 32'(model_done_idx()), 269);
      run_trace(-1);
      check("write done idx", 32'(g_done_idx), 269);
      check("write sclk rises", 32'(g_rises), 32);
      check("write mosi word", g_bits, 32'h12345678);

      // WAIT 100 then END, no reset in between (start restarts from 0).
      rom[0] = 36'h2_00000064;
      build_trace();
      check("model wait done idx", 32'(model_done_idx()), 105);
      run_trace(-1);
      check("wait done idx", 32'(g_done_idx), 105);
      check("wait sclk rises", 32'(g_rises), 0);

      // Illegal opcode: sticky fault, start ignored.
      rom[0] = 36'h7_00000000;
      build_trace();
      run_trace(-1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("fault error held", 32'(error), 1);
      check("fault busy", 32'(busy), 0);
      check("fault addr", 32'(rom_address), 0);
      do_reset();

      // Reset in the middle of bit 15, then full replay.
      pl = $urandom;
      rom[0] = {4'h1, pl};
      rom[1] = 36'h0;
      build_trace();
      run_trace(3 + 15 * 2 * H + H);
      do_reset();
      run_trace(-1);
      check("replay sclk rises", 32'(g_rises), 32);
      check("replay mosi word", g_bits, pl);

`ifdef CDCE_READBACK_EN
      // READ: write frame, latch, capture frame.
      rom[0] = 36'h3_8000000E;
      rom[1] = 36'h0;
      g_rd_word = 32'hA5A50F0F;
      build_trace();
      run_trace(-1);
      check("read rd_data", rd_data, 32'hA5A50F0F);
      check("read rd_valid pulses", 32'(g_rdv_cnt), 1);
      check("read done idx", 32'(g_done_idx), 533);
`endif

      // Random short programs.
      for (int t = 0; t < 4; t++) begin
         foreach (rom[i]) rom[i] = 36'h0;
         g_rd_word = $urandom;
         n = $urandom_range(2, 5);
         for (int k = 0; k < n; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) rom[k] = {4'h1, 32'($urandom)};
            else if (r < 8) rom[k] = {4'h2, 8'($urandom), 24'($urandom_range(0, 40))};
            else if (r == 8) rom[k] = {4'h3, 32'($urandom)};
            else rom[k] = {4'($urandom_range(4, 15)), 32'($urandom)};
         end
         build_trace();
         run_trace(-1);
         if (exp_q[exp_q.size() - 1].err) do_reset();
      end

      // 256 WRITE commands, no END: fault after address 255.
      foreach (rom[i]) rom[i] = {4'h1, 32'($urandom)};
      build_trace();
      run_trace(-1);
      check("wrap sclk rises", 32'(g_rises), 256 * 32);
      check("wrap error", 32'(error), 1);
      check("wrap busy", 32'(busy), 0);
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
